// File: rtl/seg_display_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_driver_if
// Description : Calculator-result bus into the seven-segment display driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_display_driver_if;
    logic [5:0] display_result;
    logic       display_mode;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    modport master (
        output display_result,
        output display_mode,
        input  seg,
        input  an,
        input  busy
    );

    modport slave (
        input  display_result,
        input  display_mode,
        output seg,
        output an,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/seg_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_driver
// Description : Signed-decimal / hex renderer and 4-digit multiplexed
//               seven-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_driver #(
    parameter int CLK_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    seg_display_driver_if.slave  disp
);

    localparam int              c_PW         = $clog2(CLK_DIV);
    localparam logic [c_PW-1:0] c_PRESC_MAX  = c_PW'(CLK_DIV - 1);
    localparam logic [6:0]      c_SEG_BLANK  = 7'h7F;
    localparam logic [6:0]      c_SEG_MINUS  = 7'h3F;
    localparam logic [6:0]      c_SEG_ZERO   = 7'h40;
    localparam logic [2:0]      c_LAST_ITER  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    function automatic logic [6:0] f_seg(input logic [3:0] n);
        logic [6:0] code;
        case (n)
            4'h0:    code = 7'h40;
            4'h1:    code = 7'h79;
            4'h2:    code = 7'h24;
            4'h3:    code = 7'h30;
            4'h4:    code = 7'h19;
            4'h5:    code = 7'h12;
            4'h6:    code = 7'h02;
            4'h7:    code = 7'h78;
            4'h8:    code = 7'h00;
            4'h9:    code = 7'h10;
            4'hA:    code = 7'h08;
            4'hB:    code = 7'h03;
            4'hC:    code = 7'h46;
            4'hD:    code = 7'h21;
            4'hE:    code = 7'h06;
            default: code = 7'h0E;
        endcase
        return code;
    endfunction

    state_t            r_state;
    logic              r_busy;
    logic              r_sh_mode;
    logic [5:0]        r_sh_val;
    logic [5:0]        r_mag;
    logic [7:0]        r_bcd;
    logic [2:0]        r_iter;
    logic [3:0][6:0]   r_digit;
    logic [c_PW-1:0]   r_presc;
    logic [1:0]        r_idx;
    logic [3:0]        r_an;
    logic [6:0]        r_seg;

    logic              w_change;
    logic [5:0]        w_mag_in;
    logic [7:0]        w_bcd_adj;
    logic [3:0][6:0]   w_commit;
    logic [1:0]        w_idx_next;

    assign w_change   = {disp.display_mode, disp.display_result} != {r_sh_mode, r_sh_val};
    assign w_mag_in   = disp.display_result[5] ? (~disp.display_result + 6'd1) : disp.display_result;
    assign w_bcd_adj  = {(r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4],
                         (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0]};
    assign w_idx_next = r_idx + 2'd1;

    // Hex mode ignores the BCD result and renders the raw shadow pattern.
    always_comb begin
        w_commit = {c_SEG_BLANK, c_SEG_BLANK, c_SEG_BLANK, c_SEG_BLANK};
        if (r_sh_mode) begin
            w_commit[1] = f_seg({2'b00, r_sh_val[5:4]});
            w_commit[0] = f_seg(r_sh_val[3:0]);
        end else begin
            w_commit[2] = r_sh_val[5] ? c_SEG_MINUS : c_SEG_BLANK;
            w_commit[1] = (r_bcd[7:4] == 4'd0) ? c_SEG_BLANK : f_seg(r_bcd[7:4]);
            w_commit[0] = f_seg(r_bcd[3:0]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_sh_mode <= 1'b0;
            r_sh_val  <= '0;
            r_mag     <= '0;
            r_bcd     <= '0;
            r_iter    <= '0;
            r_digit   <= {c_SEG_BLANK, c_SEG_BLANK, c_SEG_BLANK, c_SEG_ZERO};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_change) begin
                        r_sh_mode <= disp.display_mode;
                        r_sh_val  <= disp.display_result;
                        r_mag     <= w_mag_in;
                        r_bcd     <= '0;
                        r_iter    <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CONV;
                    end
                end
                S_CONV: begin
                    {r_bcd, r_mag} <= {w_bcd_adj, r_mag} << 1;
                    r_iter         <= r_iter + 3'd1;
                    if (r_iter == c_LAST_ITER) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_digit <= w_commit;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Index starts at 3 so the first prescaler wrap lands on the rightmost digit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_idx   <= 2'd3;
            r_an    <= 4'hF;
            r_seg   <= c_SEG_BLANK;
        end else if (r_presc == c_PRESC_MAX) begin
            r_presc <= '0;
            r_idx   <= w_idx_next;
            r_an    <= ~(4'b0001 << w_idx_next);
            r_seg   <= r_digit[w_idx_next];
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign disp.seg  = r_seg;
    assign disp.an   = r_an;
    assign disp.busy = r_busy;

endmodule
`default_nettype wire
